// File: rtl/periph_wb_master.sv
// periph_wb_master: single-outstanding Wishbone classic-cycle master.
// A command is taken on the cmd_* handshake, issued on the bus until ack/err,
// re-issued after rty up to MAX_RETRY times, and reported on the rsp_* side.
// Optional bus timeout is compiled in when PERIPH_WB_MASTER_TIMEOUT_EN is
// defined; without it the master waits on the bus indefinitely.
module periph_wb_master #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int MAX_RETRY      = 3
) (
  input  logic        wb_periph_clk_i,
  input  logic        wb_periph_rst_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_we_i,
  input  logic [31:0] cmd_adr_i,
  input  logic [31:0] cmd_dat_i,
  input  logic [3:0]  cmd_sel_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_dat_o,
  output logic [1:0]  rsp_status_o,
  output logic [31:0] wb_periph_adr_o,
  output logic [31:0] wb_periph_dat_o,
  output logic [3:0]  wb_periph_sel_o,
  output logic        wb_periph_we_o,
  output logic        wb_periph_cyc_o,
  output logic        wb_periph_stb_o,
  output logic [2:0]  wb_periph_cti_o,
  output logic [1:0]  wb_periph_bte_o,
  input  logic [31:0] wb_periph_dat_i,
  input  logic        wb_periph_ack_i,
  input  logic        wb_periph_err_i,
  input  logic        wb_periph_rty_i
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_GAP  = 2'd2,
    S_RESP = 2'd3
  } state_e;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_ERR     = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;
  localparam logic [1:0] ST_RTY_EXH = 2'b11;

  // Retry counter only needs to reach MAX_RETRY; keep at least one bit.
  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("periph_wb_master: TIMEOUT_CYCLES must be in 1..65535");
  end
  if (MAX_RETRY < 0) begin : g_bad_retry
    $error("periph_wb_master: MAX_RETRY must be non-negative");
  end

  state_e         state_q, state_d;
  logic [31:0]    adr_q, adr_d;
  logic [31:0]    dat_q, dat_d;
  logic [3:0]     sel_q, sel_d;
  logic           we_q, we_d;
  logic           cyc_q, cyc_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic [31:0]    rsp_dat_q, rsp_dat_d;
  logic [1:0]     rsp_status_q, rsp_status_d;
  logic [RW-1:0]  retry_q, retry_d;
`ifdef PERIPH_WB_MASTER_TIMEOUT_EN
  // Counter holds the number of BUS cycles already spent without termination;
  // the attempt gives up in the cycle where it reaches TIMEOUT_CYCLES-1.
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0]    tmo_q, tmo_d;
`endif

  // Next-state, request capture, termination handling and response formation.
  always_comb begin
    state_d      = state_q;
    adr_d        = adr_q;
    dat_d        = dat_q;
    sel_d        = sel_q;
    we_d         = we_q;
    rsp_dat_d    = rsp_dat_q;
    rsp_status_d = rsp_status_q;
    retry_d      = retry_q;
`ifdef PERIPH_WB_MASTER_TIMEOUT_EN
    tmo_d        = tmo_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (cmd_valid_i) begin
          adr_d   = cmd_adr_i;
          dat_d   = cmd_dat_i;
          sel_d   = cmd_sel_i;
          we_d    = cmd_we_i;
          retry_d = '0;
`ifdef PERIPH_WB_MASTER_TIMEOUT_EN
          tmo_d   = '0;
`endif
          state_d = S_BUS;
        end
      end
      S_BUS: begin
        if (wb_periph_ack_i) begin
          rsp_status_d = ST_OK;
          rsp_dat_d    = we_q ? 32'h0 : wb_periph_dat_i;
          state_d      = S_RESP;
        end else if (wb_periph_err_i) begin
          rsp_status_d = ST_ERR;
          rsp_dat_d    = 32'h0;
          state_d      = S_RESP;
        end else if (wb_periph_rty_i) begin
          if (retry_q < RETRY_LIMIT) begin
            retry_d = retry_q + 1'b1;
            state_d = S_GAP;
          end else begin
            rsp_status_d = ST_RTY_EXH;
            rsp_dat_d    = 32'h0;
            state_d      = S_RESP;
          end
`ifdef PERIPH_WB_MASTER_TIMEOUT_EN
        end else if (tmo_q == TMO_LAST) begin
          rsp_status_d = ST_TIMEOUT;
          rsp_dat_d    = 32'h0;
          state_d      = S_RESP;
        end else begin
          tmo_d = tmo_q + 16'd1;
`endif
        end
      end
      S_GAP: begin
`ifdef PERIPH_WB_MASTER_TIMEOUT_EN
        tmo_d   = '0;
`endif
        state_d = S_BUS;
      end
      S_RESP: begin
        if (rsp_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Bus strobe and response valid are registered copies of the next state.
    cyc_d       = (state_d == S_BUS);
    rsp_valid_d = (state_d == S_RESP);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge wb_periph_clk_i) begin
    if (wb_periph_rst_i) begin
      state_q      <= S_IDLE;
      adr_q        <= '0;
      dat_q        <= '0;
      sel_q        <= '0;
      we_q         <= 1'b0;
      cyc_q        <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_dat_q    <= '0;
      rsp_status_q <= ST_OK;
      retry_q      <= '0;
`ifdef PERIPH_WB_MASTER_TIMEOUT_EN
      tmo_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      adr_q        <= adr_d;
      dat_q        <= dat_d;
      sel_q        <= sel_d;
      we_q         <= we_d;
      cyc_q        <= cyc_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_dat_q    <= rsp_dat_d;
      rsp_status_q <= rsp_status_d;
      retry_q      <= retry_d;
`ifdef PERIPH_WB_MASTER_TIMEOUT_EN
      tmo_q        <= tmo_d;
`endif
    end
  end

  // Ready is masked by the reset input so nothing is taken while reset is held.
  assign cmd_ready_o     = (state_q == S_IDLE) && !wb_periph_rst_i;
  assign rsp_valid_o     = rsp_valid_q;
  assign rsp_dat_o       = rsp_dat_q;
  assign rsp_status_o    = rsp_status_q;
  assign wb_periph_adr_o = adr_q;
  assign wb_periph_dat_o = dat_q;
  assign wb_periph_sel_o = sel_q;
  assign wb_periph_we_o  = we_q;
  assign wb_periph_cyc_o = cyc_q;
  assign wb_periph_stb_o = cyc_q;
  assign wb_periph_cti_o = 3'b000;
  assign wb_periph_bte_o = 2'b00;

endmodule

// File: tb/tb_periph_wb_master.sv
// Scoreboard bench for periph_wb_master: stimulus pushes expected responses,
// a monitor pops them on every rsp handshake; bus-side timing checked inline.
module tb_periph_wb_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [31:0] cmd_adr, cmd_dat;
  logic [3:0]  cmd_sel;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_dat;
  logic [1:0]  rsp_status;
  logic [31:0] wb_adr, wb_dat_o, wb_dat_i;
  logic [3:0]  wb_sel;
  logic        wb_we, wb_cyc, wb_stb;
  logic [2:0]  wb_cti;
  logic [1:0]  wb_bte;
  logic        wb_ack, wb_err, wb_rty;

  always #5 clk = ~clk;

  periph_wb_master #(.TIMEOUT_CYCLES(16), .MAX_RETRY(3)) dut (
    .wb_periph_clk_i (clk),
    .wb_periph_rst_i (rst),
    .cmd_valid_i     (cmd_valid),
    .cmd_ready_o     (cmd_ready),
    .cmd_we_i        (cmd_we),
    .cmd_adr_i       (cmd_adr),
    .cmd_dat_i       (cmd_dat),
    .cmd_sel_i       (cmd_sel),
    .rsp_valid_o     (rsp_valid),
    .rsp_ready_i     (rsp_ready),
    .rsp_dat_o       (rsp_dat),
    .rsp_status_o    (rsp_status),
    .wb_periph_adr_o (wb_adr),
    .wb_periph_dat_o (wb_dat_o),
    .wb_periph_sel_o (wb_sel),
    .wb_periph_we_o  (wb_we),
    .wb_periph_cyc_o (wb_cyc),
    .wb_periph_stb_o (wb_stb),
    .wb_periph_cti_o (wb_cti),
    .wb_periph_bte_o (wb_bte),
    .wb_periph_dat_i (wb_dat_i),
    .wb_periph_ack_i (wb_ack),
    .wb_periph_err_i (wb_err),
    .wb_periph_rty_i (wb_rty)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [33:0] exp_q[$];
  logic [33:0] mon_exp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Response scoreboard: every accepted response must match the oldest expectation.
  always @(negedge clk) begin
    if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rsp_unexpected: got status %0d dat 0x%0h, expected no response",
                 rsp_status, rsp_dat);
      end else begin
        mon_exp = exp_q.pop_front();
        check("rsp_status", 32'(rsp_status), 32'(mon_exp[33:32]));
        check("rsp_dat", rsp_dat, mon_exp[31:0]);
      end
    end
  end

  // Bus activity monitor: lengths of cyc bursts and of the idle gaps between them.
  int run = 0, last_run = 0, idle_run = 0, last_gap = 0, bursts = 0;
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      run = 0;
      idle_run = 0;
    end else if (wb_cyc === 1'b1) begin
      if (run == 0) begin
        last_gap = idle_run;
        bursts++;
      end
      run++;
      idle_run = 0;
    end else begin
      if (run > 0) last_run = run;
      run = 0;
      idle_run++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel);
    int k = 0;
    while (cmd_ready !== 1'b1 && k < 50) begin
      tick();
      k++;
    end
    if (cmd_ready !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL cmd_ready_wait: got cmd_ready %b, expected 1 within 50 cycles", cmd_ready);
    end
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_adr   = adr;
    cmd_dat   = dat;
    cmd_sel   = sel;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while (exp_q.size() != 0 && k < 100) begin
      tick();
      k++;
    end
    tick();
    tick();
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
  endtask

  int b0;

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected finish before 200us");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0; cmd_sel = '0;
    rsp_ready = 1'b1; wb_dat_i = '0; wb_ack = 1'b0; wb_err = 1'b0; wb_rty = 1'b0;

    // Reset values
    repeat (3) tick();
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_cyc", 32'(wb_cyc), 32'd0);
    check("rst_stb", 32'(wb_stb), 32'd0);
    check("rst_we", 32'(wb_we), 32'd0);
    check("rst_adr", wb_adr, 32'd0);
    check("rst_dat", wb_dat_o, 32'd0);
    check("rst_sel", 32'(wb_sel), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_dat", rsp_dat, 32'd0);
    check("rst_rsp_status", 32'(rsp_status), 32'd0);
    check("cti", 32'(wb_cti), 32'd0);
    check("bte", 32'(wb_bte), 32'd0);
    rst = 1'b0;
    tick();
    check("cmd_ready_after_rst", 32'(cmd_ready), 32'd1);

    // Write with two wait states
    exp_q.push_back({2'b00, 32'h0});
    issue(1'b1, 32'h0, 32'hDEADBEEF, 4'hF);
    check("wr_cyc", 32'(wb_cyc), 32'd1);
    check("wr_stb", 32'(wb_stb), 32'd1);
    check("wr_we", 32'(wb_we), 32'd1);
    check("wr_adr", wb_adr, 32'h0);
    check("wr_dat", wb_dat_o, 32'hDEADBEEF);
    check("wr_sel", 32'(wb_sel), 32'hF);
    tick();
    tick();
    check("wr_cyc_c3", 32'(wb_cyc), 32'd1);
    check("wr_dat_c3", wb_dat_o, 32'hDEADBEEF);
    wb_ack = 1'b1;
    tick();
    wb_ack = 1'b0;
    check("wr_cyc_drop", 32'(wb_cyc), 32'd0);
    check("wr_rsp_valid", 32'(rsp_valid), 32'd1);
    drain();
    check("wr_cyc_len", 32'(last_run), 32'd3);
    check("idle_we_hold", 32'(wb_we), 32'd1);
    check("idle_dat_hold", wb_dat_o, 32'hDEADBEEF);

    // Read with immediate ack
    exp_q.push_back({2'b00, 32'hDEADBEEF});
    issue(1'b0, 32'h1, 32'h0, 4'hF);
    check("rd_adr", wb_adr, 32'h1);
    check("rd_we", 32'(wb_we), 32'd0);
    wb_ack = 1'b1;
    wb_dat_i = 32'hDEADBEEF;
    tick();
    wb_ack = 1'b0;
    wb_dat_i = 32'h0;
    check("rd_cyc_drop", 32'(wb_cyc), 32'd0);
    check("rd_rsp_valid", 32'(rsp_valid), 32'd1);
    check("rd_rsp_dat_direct", rsp_dat, 32'hDEADBEEF);
    drain();
    check("rd_cyc_len", 32'(last_run), 32'd1);

    // Error on read: data forced to zero
    exp_q.push_back({2'b01, 32'h0});
    issue(1'b0, 32'h8, 32'h0, 4'hF);
    wb_err = 1'b1;
    wb_dat_i = 32'hCAFEF00D;
    tick();
    wb_err = 1'b0;
    wb_dat_i = 32'h0;
    drain();

    // err beats rty in the same cycle: no re-issue
    b0 = bursts;
    exp_q.push_back({2'b01, 32'h0});
    issue(1'b0, 32'hC, 32'h0, 4'hF);
    wb_err = 1'b1;
    wb_rty = 1'b1;
    tick();
    wb_err = 1'b0;
    wb_rty = 1'b0;
    drain();
    check("err_rty_bursts", 32'(bursts - b0), 32'd1);

    // One retry, then ack on an identical re-issue
    exp_q.push_back({2'b00, 32'h0});
    issue(1'b1, 32'h40, 32'h1234A5A5, 4'h3);
    wb_rty = 1'b1;
    tick();
    wb_rty = 1'b0;
    check("gap_cyc", 32'(wb_cyc), 32'd0);
    tick();
    check("reissue_cyc", 32'(wb_cyc), 32'd1);
    check("reissue_adr", wb_adr, 32'h40);
    check("reissue_dat", wb_dat_o, 32'h1234A5A5);
    check("reissue_sel", 32'(wb_sel), 32'h3);
    check("reissue_we", 32'(wb_we), 32'd1);
    wb_ack = 1'b1;
    tick();
    wb_ack = 1'b0;
    drain();

    // Retry exhaustion: 4 single-cycle attempts separated by one idle cycle
    b0 = bursts;
    exp_q.push_back({2'b11, 32'h0});
    wb_rty = 1'b1;
    issue(1'b0, 32'h2, 32'h0, 4'hF);
    repeat (12) tick();
    wb_rty = 1'b0;
    drain();
    check("rty_attempts", 32'(bursts - b0), 32'd4);
    check("rty_gap", 32'(last_gap), 32'd1);
    check("rty_len", 32'(last_run), 32'd1);

    // ack+err together, response back-pressured for 5 cycles
    rsp_ready = 1'b0;
    exp_q.push_back({2'b00, 32'h12345678});
    issue(1'b0, 32'h3, 32'h0, 4'hF);
    wb_ack = 1'b1;
    wb_err = 1'b1;
    wb_dat_i = 32'h12345678;
    tick();
    wb_ack = 1'b0;
    wb_err = 1'b0;
    wb_dat_i = 32'h0;
    cmd_valid = 1'b1;
    cmd_adr = 32'h99;
    for (int i = 0; i < 5; i++) begin
      check("hold_rsp_valid", 32'(rsp_valid), 32'd1);
      check("hold_rsp_dat", rsp_dat, 32'h12345678);
      check("hold_rsp_status", 32'(rsp_status), 32'd0);
      check("hold_cmd_ready", 32'(cmd_ready), 32'd0);
      tick();
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    drain();

`ifdef PERIPH_WB_MASTER_TIMEOUT_EN
    // Silent slave: abort after 16 bus cycles
    exp_q.push_back({2'b10, 32'h0});
    issue(1'b0, 32'h4, 32'h0, 4'hF);
    repeat (20) tick();
    drain();
    check("tmo_cyc_len", 32'(last_run), 32'd16);
`else
    // Silent slave: bus waits indefinitely, cleared only by reset
    issue(1'b0, 32'h4, 32'h0, 4'hF);
    repeat (1005) tick();
    check("stall_cyc", 32'(wb_cyc), 32'd1);
    check("stall_run_ge_1000", 32'(run >= 1000), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    check("stall_abort_cyc", 32'(wb_cyc), 32'd0);
    drain();
`endif

    // Reset in the third cycle of a stalled bus cycle
    issue(1'b1, 32'h5, 32'h11, 4'hF);
    tick();
    tick();
    check("pre_rst_cyc", 32'(wb_cyc), 32'd1);
    rst = 1'b1;
    tick();
    check("abort_cyc", 32'(wb_cyc), 32'd0);
    check("abort_stb", 32'(wb_stb), 32'd0);
    check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    check("abort_cmd_ready", 32'(cmd_ready), 32'd0);
    rst = 1'b0;
    tick();
    check("release_cmd_ready", 32'(cmd_ready), 32'd1);
    check("release_rsp_valid", 32'(rsp_valid), 32'd0);
    repeat (3) tick();
    check("no_abort_rsp", 32'(rsp_valid), 32'd0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
